forward_unit: RTL and testbench

- EX-stage data-forwarding unit for the 5-stage MIPS pipeline.
- Compares the ID/EX source registers (Rs, Rt) against the destination registers of the instructions in EX/MEM and MEM/WB.
- Produces 2-bit ALU-operand mux selects ForwardA and ForwardB.
- Includes clocked, saturating forwarding-event counters for performance and debug observation.

---
 rtl/forward_unit.sv | 74 +++++++
 tb/tb_forward_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX-stage operand forwarding selects with saturating event counters
module forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EXMEM_RegWrite,
  input  logic [REG_ADDR_W-1:0] EXMEM_Rd,
  input  logic                  MEMWB_RegWrite,
  input  logic [REG_ADDR_W-1:0] MEMWB_Rd,
  input  logic [REG_ADDR_W-1:0] IDEX_Rs,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic [CNT_W-1:0]      fwd_exmem_cnt,
  output logic [CNT_W-1:0]      fwd_memwb_cnt
);

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;

  logic             exmem_live;
  logic             memwb_live;
  logic [1:0]       exmem_inc;
  logic [1:0]       memwb_inc;
  logic [CNT_W:0]   exmem_sum;
  logic [CNT_W:0]   memwb_sum;
  logic [CNT_W-1:0] exmem_cnt_d, exmem_cnt_q;
  logic [CNT_W-1:0] memwb_cnt_d, memwb_cnt_q;

  // $zero is hardwired, so a write to r0 never produces a forwardable value
  assign exmem_live = EXMEM_RegWrite && (EXMEM_Rd != '0);
  assign memwb_live = MEMWB_RegWrite && (MEMWB_Rd != '0);

  always_comb begin
    ForwardA = SEL_REG;
    if (exmem_live && (EXMEM_Rd == IDEX_Rs)) ForwardA = SEL_EXMEM;
    else if (memwb_live && (MEMWB_Rd == IDEX_Rs)) ForwardA = SEL_MEMWB;
  end

  always_comb begin
    ForwardB = SEL_REG;
    if (exmem_live && (EXMEM_Rd == IDEX_Rt)) ForwardB = SEL_EXMEM;
    else if (memwb_live && (MEMWB_Rd == IDEX_Rt)) ForwardB = SEL_MEMWB;
  end

  assign exmem_inc = {1'b0, ForwardA == SEL_EXMEM} + {1'b0, ForwardB == SEL_EXMEM};
  assign memwb_inc = {1'b0, ForwardA == SEL_MEMWB} + {1'b0, ForwardB == SEL_MEMWB};

  // One extra sum bit catches overflow from an increment of up to 2
  assign exmem_sum = {1'b0, exmem_cnt_q} + {{(CNT_W-1){1'b0}}, exmem_inc};
  assign memwb_sum = {1'b0, memwb_cnt_q} + {{(CNT_W-1){1'b0}}, memwb_inc};

  always_comb begin
    exmem_cnt_d = exmem_sum[CNT_W] ? {CNT_W{1'b1}} : exmem_sum[CNT_W-1:0];
    memwb_cnt_d = memwb_sum[CNT_W] ? {CNT_W{1'b1}} : memwb_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_cnt_q <= '0;
      memwb_cnt_q <= '0;
    end else begin
      exmem_cnt_q <= exmem_cnt_d;
      memwb_cnt_q <= memwb_cnt_d;
    end
  end

  assign fwd_exmem_cnt = exmem_cnt_q;
  assign fwd_memwb_cnt = memwb_cnt_q;

endmodule

// File: tb/tb_forward_unit.sv
// tb/tb_forward_unit.sv - table-driven bench for forward_unit with counter scoreboard
module tb_forward_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       exw, mww;
  logic [4:0] exrd, mwrd, rs, rt;
  logic [1:0] fa, fb, fa4, fb4;
  logic [15:0] ex_cnt, mw_cnt;
  logic [3:0]  ex_cnt4, mw_cnt4;

  always #5 clk = ~clk;

  forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .EXMEM_RegWrite(exw), .EXMEM_Rd(exrd),
    .MEMWB_RegWrite(mww), .MEMWB_Rd(mwrd),
    .IDEX_Rs(rs), .IDEX_Rt(rt),
    .ForwardA(fa), .ForwardB(fb),
    .fwd_exmem_cnt(ex_cnt), .fwd_memwb_cnt(mw_cnt)
  );

  forward_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .EXMEM_RegWrite(exw), .EXMEM_Rd(exrd),
    .MEMWB_RegWrite(mww), .MEMWB_Rd(mwrd),
    .IDEX_Rs(rs), .IDEX_Rt(rt),
    .ForwardA(fa4), .ForwardB(fb4),
    .fwd_exmem_cnt(ex_cnt4), .fwd_memwb_cnt(mw_cnt4)
  );

  typedef struct {
    logic       rst;
    logic       exw;
    logic [4:0] exrd;
    logic       mww;
    logic [4:0] mwrd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  typedef struct {
    int ex;
    int mw;
    int ex4;
    int mw4;
  } cnt_t;

  cnt_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_ex, m_mw, m_ex4, m_mw4;

  function automatic int sat(int v, int inc, int w);
    int r;
    int mx;
    r  = v + inc;
    mx = (1 << w) - 1;
    return (r > mx) ? mx : r;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(string tag);
    cnt_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({tag, " exmem_cnt"},  int'(ex_cnt),  e.ex);
    check({tag, " memwb_cnt"},  int'(mw_cnt),  e.mw);
    check({tag, " exmem_cnt4"}, int'(ex_cnt4), e.ex4);
    check({tag, " memwb_cnt4"}, int'(mw_cnt4), e.mw4);
  endtask

  task automatic apply(vec_t v, string tag);
    int ie, im;
    cnt_t e;
    @(negedge clk);
    pop_check(tag);
    reset = v.rst; exw = v.exw; exrd = v.exrd; mww = v.mww; mwrd = v.mwrd;
    rs = v.rs; rt = v.rt;
    #1;
    check({tag, " ForwardA"}, int'(fa), int'(v.ea));
    check({tag, " ForwardB"}, int'(fb), int'(v.eb));
    check({tag, " ForwardA w4"}, int'(fa4), int'(v.ea));
    check({tag, " ForwardB w4"}, int'(fb4), int'(v.eb));
    ie = int'(v.ea == 2'b10) + int'(v.eb == 2'b10);
    im = int'(v.ea == 2'b01) + int'(v.eb == 2'b01);
    if (v.rst) begin
      m_ex = 0; m_mw = 0; m_ex4 = 0; m_mw4 = 0;
    end else begin
      m_ex  = sat(m_ex,  ie, 16);
      m_mw  = sat(m_mw,  im, 16);
      m_ex4 = sat(m_ex4, ie, 4);
      m_mw4 = sat(m_mw4, im, 4);
    end
    e.ex = m_ex; e.mw = m_mw; e.ex4 = m_ex4; e.mw4 = m_mw4;
    sb_q.push_back(e);
  endtask

  vec_t tbl[13];
  vec_t dbl;
  vec_t rstv;

  initial begin
    reset = 1'b1; exw = 1'b0; mww = 1'b0; exrd = '0; mwrd = '0; rs = '0; rt = '0;
    m_ex = 0; m_mw = 0; m_ex4 = 0; m_mw4 = 0;

    //             rst   exw   exrd  mww   mwrd  rs     rt     A      B
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00};
    tbl[1]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 5'd3, 1'b0, 5'd0,  5'd3,  5'd0,  2'b10, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 5'd3, 1'b0, 5'd0,  5'd3,  5'd3,  2'b10, 2'b10};
    tbl[4]  = '{1'b0, 1'b0, 5'd3, 1'b0, 5'd0,  5'd3,  5'd3,  2'b00, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd1,  5'd3,  5'd1,  2'b10, 2'b01};
    tbl[6]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd1,  5'd3,  5'd1,  2'b10, 2'b01};
    tbl[7]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd3,  5'd3,  5'd3,  2'b10, 2'b10};
    tbl[8]  = '{1'b0, 1'b1, 5'd0, 1'b1, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 5'd5, 1'b1, 5'd5,  5'd5,  5'd5,  2'b01, 2'b01};
    tbl[10] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd5,  5'd5,  5'd7,  2'b00, 2'b10};
    tbl[11] = '{1'b1, 1'b1, 5'd2, 1'b0, 5'd0,  5'd2,  5'd2,  2'b10, 2'b10};
    tbl[12] = '{1'b0, 1'b1, 5'd4, 1'b1, 5'd31, 5'd31, 5'd4,  2'b01, 2'b10};

    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // continuous double EX/MEM forwarding drives the 4-bit counter into saturation
    dbl = '{1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd9, 2'b10, 2'b10};
    for (int i = 0; i < 10; i++) apply(dbl, $sformatf("sat%0d", i));

    // reset in the middle of forwarding activity
    rstv = '{1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd9, 2'b10, 2'b10};
    apply(rstv, "midrst");
    apply(dbl, "postrst");

    @(negedge clk);
    pop_check("flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
